// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with an optional skid entry.
// Holds up to two beats (one when SKID_EN=0); flush squashes everything held.
module pipe_skid_stage #(
    parameter int                DATA_W    = 71,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
    parameter int                SKID_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_rdy;
    logic              w_rdy_nxt;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_skid_ok;

    // The state encoding doubles as the occupancy count.
    assign count      = r_state;
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_skid_ok  = (SKID_EN != 0);

    if (SKID_EN != 0) begin : g_skid
        assign in_ready  = r_rdy;
        assign w_rdy_nxt = (w_state_nxt != FULL);
    end else begin : g_noskid
        // Without a skid slot a held beat can only be replaced as it leaves.
        assign in_ready  = r_rdy || ((r_state == ONE) && out_ready);
        assign w_rdy_nxt = (w_state_nxt == EMPTY);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = CLEAR_VAL;
            w_skid_nxt  = CLEAR_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        w_in_xfer && w_out_xfer: begin
                            w_main_nxt = in_data;
                        end
                        !w_in_xfer && w_out_xfer: begin
                            w_state_nxt = EMPTY;
                            w_main_nxt  = CLEAR_VAL;
                        end
                        w_in_xfer && !w_out_xfer && w_skid_ok: begin
                            w_state_nxt = FULL;
                            w_skid_nxt  = in_data;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    if (w_out_xfer) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = CLEAR_VAL;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = CLEAR_VAL;
                    w_skid_nxt  = CLEAR_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= CLEAR_VAL;
            r_skid  <= CLEAR_VAL;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_rdy   <= w_rdy_nxt;
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 71, giving the payload width (MEM/WB bundle: syscall, WE, RW[4:0], A[31:0], w[31:0]).
REQ-002 The module SHALL have parameter CLEAR_VAL, default all-zero DATA_W bits, giving the bubble/flush payload value.
REQ-003 The module SHALL have parameter SKID_EN, default 1, where 1 gives a two-entry skid buffer and 0 gives a single-entry stage.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream beat is present.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the stage can accept a beat; it is registered.
REQ-008 The module SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-010 The module SHALL have port out_ready, input, 1 bit: downstream accepts the beat (replaces the old go).
REQ-011 The module SHALL have port out_data, output, DATA_W bits: the payload, driven only from registers.
REQ-012 The module SHALL have port flush, input, 1 bit: a synchronous squash of all held beats (replaces the old clear).
REQ-013 The module SHALL have port count, output, 2 bits: the number of held beats, 0..2.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready at a clock edge, and an output transfer SHALL occur when out_valid && out_ready at a clock edge.
REQ-015 The stage SHALL have three states: EMPTY (count 0), ONE (main register valid, count 1) and FULL (main and skid valid, count 2); FULL is unreachable when SKID_EN=0.
REQ-016 From EMPTY, an input transfer SHALL load main from in_data and move to ONE.
REQ-017 In ONE, simultaneous input and output transfers SHALL load main from in_data and stay in ONE.
REQ-018 In ONE, an output transfer alone SHALL move to EMPTY and set main to CLEAR_VAL.
REQ-019 In ONE with SKID_EN=1, an input transfer alone SHALL load skid from in_data and move to FULL.
REQ-020 In ONE, no transfer SHALL hold main unchanged.
REQ-021 In FULL, an output transfer SHALL copy skid to main, clear skid to CLEAR_VAL and move to ONE; otherwise FULL SHALL hold.
REQ-022 in_ready SHALL be registered: with SKID_EN=1 it is 1 in the cycle after the next state is EMPTY or ONE, and with SKID_EN=0 it is 1 in the cycle after the next state is EMPTY or the stage holds ONE with out_ready high.
REQ-023 With SKID_EN=0, in_ready SHALL be (next state is EMPTY) || out_ready, and in_ready is the one permitted combinational path.
REQ-024 Latency SHALL be 1 cycle from an input transfer to out_valid, and throughput SHALL be 1 beat/cycle when out_ready is held high.
REQ-025 Beats SHALL leave in arrival order, with none dropped or duplicated except under flush.
REQ-026 flush SHALL have the highest priority: the next state is EMPTY, main and skid become CLEAR_VAL, count becomes 0, and any input or output transfer in that cycle is discarded or not counted.
REQ-027 out_data SHALL equal CLEAR_VAL whenever out_valid is 0.
REQ-028 A stalled beat SHALL hold out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst_n=0, the stage SHALL set state EMPTY, out_valid=0, out_data=CLEAR_VAL, skid=CLEAR_VAL, count=0 and in_ready=0, immediately and without waiting for clk.
REQ-030 At the first rising clk after rst_n rises, the stage SHALL set in_ready=1, and no transfer SHALL occur in that cycle.
REQ-031 Reset asserted mid-operation SHALL discard all held beats.

Verification
REQ-032 The bench SHALL cover streaming: out_ready=1, beats 0x1..0x5 on consecutive cycles -> out_data 0x1..0x5 on consecutive cycles, each one cycle later, with count=1 throughout.
REQ-033 The bench SHALL cover backpressure: beats A=0x11, B=0x22 with out_ready=0 -> count=2, in_ready=0, out_data=0x11 held; then out_ready=1 -> 0x11 then 0x22, and in_ready returns to 1.
REQ-034 The bench SHALL cover flush in FULL: flush=1 with in_valid=1 and in_data=0x33 -> next cycle count=0, out_valid=0, out_data=CLEAR_VAL, and 0x33 never appears.
REQ-035 The bench SHALL cover simultaneous flush and out_ready in ONE -> the beat is not counted as delivered, and the stage is EMPTY.
REQ-036 The bench SHALL cover async reset mid-stream: rst_n=0 between clk edges -> out_valid=0 and count=0 immediately; after release, in_ready=0 for one edge then 1.
REQ-037 The bench SHALL cover SKID_EN=0: out_ready=0 with one beat held -> in_ready=0, count never exceeds 1; out_ready=1 with in_valid=1 -> 1 beat/cycle.
